ber_test_controller: RTL and testbench

BER_TEST_CONTROLLER -- requirements
Module: ber_test_controller

---
 rtl/ber_pkg.sv | 30 +++
 rtl/ber_test_controller_if.sv | 31 +++
 rtl/ber_window_counter.sv | 43 ++++
 rtl/ber_test_controller.sv | 172 +++++++++++++++++
 tb/tb_ber_test_controller.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ber_pkg.sv
// Shared state encoding, counter widths and window-length lookup for the BER test controller.
package ber_pkg;

  localparam int unsigned SymCntW = 21;
  localparam int unsigned ErrCntW = 22;
  localparam logic [ErrCntW-1:0] ErrCntMax = {ErrCntW{1'b1}};

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StSettle  = 3'd2,
    StSync    = 3'd3,
    StMeasure = 3'd4,
    StDone    = 3'd5,
    StFail    = 3'd6
  } ber_state_e;

  // Window length is 2^(14 + 2*sel) symbols.
  function automatic logic [SymCntW-1:0] win_len(input logic [1:0] sel);
    logic [SymCntW-1:0] len;
    unique case (sel)
      2'd0:    len = 21'h004000;
      2'd1:    len = 21'h010000;
      2'd2:    len = 21'h040000;
      default: len = 21'h100000;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ber_test_controller_if.sv
// Control/status bundle between a BER test master and the controller.
interface ber_test_controller_if;
  import ber_pkg::*;

  logic               sam_clk_en;
  logic               sym_clk_en;
  logic               start;
  logic               abort;
  logic               continuous;
  logic [1:0]         window_sel;
  logic [8:0]         sync_thresh;
  logic               err_in;
  logic               lfsr_load;
  logic [ErrCntW-1:0] ber_errors;
  logic [SymCntW-1:0] ber_symbols;
  logic               result_valid;
  logic               busy;
  logic               sync_fail;
  logic [2:0]         state;

  modport master (
    output sam_clk_en, sym_clk_en, start, abort, continuous, window_sel, sync_thresh, err_in,
    input  lfsr_load, ber_errors, ber_symbols, result_valid, busy, sync_fail, state
  );

  modport slave (
    input  sam_clk_en, sym_clk_en, start, abort, continuous, window_sel, sync_thresh, err_in,
    output lfsr_load, ber_errors, ber_symbols, result_valid, busy, sync_fail, state
  );

endinterface

// File: rtl/ber_window_counter.sv
// Symbol counter with programmable terminal count plus saturating error counter.
module ber_window_counter
  import ber_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               sym_en_i,
  input  logic               err_en_i,
  input  logic [SymCntW-1:0] term_cnt_i,
  output logic [ErrCntW-1:0] err_nxt_o,
  output logic               last_o
);

  logic [SymCntW-1:0] sym_cnt_q, sym_cnt_d;
  logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    // err_nxt_o includes an error arriving with the final symbol.
    err_nxt_o = err_cnt_q;
    if (err_en_i && (err_cnt_q != ErrCntMax)) begin
      err_nxt_o = err_cnt_q + ErrCntW'(1);
    end
    last_o    = sym_en_i && (sym_cnt_q == (term_cnt_i - SymCntW'(1)));
    sym_cnt_d = sym_en_i ? (sym_cnt_q + SymCntW'(1)) : sym_cnt_q;
    err_cnt_d = err_nxt_o;
    if (clr_i) begin
      sym_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sym_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      sym_cnt_q <= sym_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: rtl/ber_test_controller.sv
// BER test sequencer: LFSR load, settle, sync check with retries, then windowed error counting.
module ber_test_controller
  import ber_pkg::*;
#(
  parameter int unsigned LFSR_LEN    = 22,
  parameter int unsigned SETTLE_SYMS = 32,
  parameter int unsigned SYNC_SYMS   = 256,
  parameter int unsigned MAX_RETRY   = 3
) (
  input logic                  sys_clk,
  input logic                  reset,
  ber_test_controller_if.slave bus_io
);

  ber_state_e         state_q, state_d;
  logic [SymCntW-1:0] win_len_q, win_len_d;
  logic [7:0]         retry_q, retry_d;
  logic               sync_fail_q, sync_fail_d;
  logic [ErrCntW-1:0] ber_errors_q, ber_errors_d;
  logic [SymCntW-1:0] ber_symbols_q, ber_symbols_d;
  logic               lfsr_load_q, result_valid_q, busy_q;

  logic               cnt_clr, cnt_sym_en, cnt_err_en, cnt_last;
  logic [SymCntW-1:0] cnt_term;
  logic [ErrCntW-1:0] cnt_err_nxt;
  logic               qual_err;

  assign qual_err = bus_io.sam_clk_en & bus_io.err_in;

  ber_window_counter u_win_cnt (
    .clk_i      (sys_clk),
    .rst_ni     (reset),
    .clr_i      (cnt_clr),
    .sym_en_i   (cnt_sym_en),
    .err_en_i   (cnt_err_en),
    .term_cnt_i (cnt_term),
    .err_nxt_o  (cnt_err_nxt),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d       = state_q;
    win_len_d     = win_len_q;
    retry_d       = retry_q;
    sync_fail_d   = sync_fail_q;
    ber_errors_d  = ber_errors_q;
    ber_symbols_d = ber_symbols_q;
    cnt_clr       = 1'b0;
    cnt_sym_en    = 1'b0;
    cnt_err_en    = 1'b0;
    cnt_term      = win_len_q;

    unique case (state_q)
      StIdle: begin
        cnt_clr = 1'b1;
        if (bus_io.start) begin
          state_d     = StLoad;
          win_len_d   = win_len(bus_io.window_sel);
          retry_d     = '0;
          sync_fail_d = 1'b0;
        end
      end
      StLoad: begin
        // The counter tracks sample strobes while the checker LFSR fills.
        cnt_sym_en = bus_io.sam_clk_en;
        cnt_term   = SymCntW'(LFSR_LEN);
        if (cnt_last) begin
          state_d = StSettle;
          cnt_clr = 1'b1;
        end
      end
      StSettle: begin
        cnt_sym_en = bus_io.sym_clk_en;
        cnt_term   = SymCntW'(SETTLE_SYMS);
        if (cnt_last) begin
          state_d = StSync;
          cnt_clr = 1'b1;
        end
      end
      StSync: begin
        cnt_sym_en = bus_io.sym_clk_en;
        cnt_err_en = qual_err;
        cnt_term   = SymCntW'(SYNC_SYMS);
        if (cnt_last) begin
          cnt_clr = 1'b1;
          if (cnt_err_nxt <= ErrCntW'(bus_io.sync_thresh)) begin
            state_d = StMeasure;
          end else begin
            retry_d = retry_q + 8'd1;
            state_d = (retry_d == 8'(MAX_RETRY)) ? StFail : StLoad;
          end
        end
      end
      StMeasure: begin
        cnt_sym_en = bus_io.sym_clk_en;
        cnt_err_en = qual_err;
        if (cnt_last) begin
          state_d       = StDone;
          cnt_clr       = 1'b1;
          ber_errors_d  = cnt_err_nxt;
          ber_symbols_d = win_len_q;
        end
      end
      StDone: begin
        // Counters were cleared on entry; strobes here belong to the next window.
        if (bus_io.continuous) begin
          state_d    = StMeasure;
          cnt_sym_en = bus_io.sym_clk_en;
          cnt_err_en = qual_err;
        end else begin
          state_d = StIdle;
          cnt_clr = 1'b1;
        end
      end
      StFail: begin
        state_d = StIdle;
        cnt_clr = 1'b1;
      end
      default: begin
        state_d = StIdle;
        cnt_clr = 1'b1;
      end
    endcase

    if (state_d == StFail) begin
      sync_fail_d = 1'b1;
    end

    if (bus_io.abort) begin
      state_d       = StIdle;
      cnt_clr       = 1'b1;
      retry_d       = '0;
      win_len_d     = win_len_q;
      sync_fail_d   = sync_fail_q;
      ber_errors_d  = ber_errors_q;
      ber_symbols_d = ber_symbols_q;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      win_len_q      <= '0;
      retry_q        <= '0;
      sync_fail_q    <= 1'b0;
      ber_errors_q   <= '0;
      ber_symbols_q  <= '0;
      lfsr_load_q    <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      win_len_q      <= win_len_d;
      retry_q        <= retry_d;
      sync_fail_q    <= sync_fail_d;
      ber_errors_q   <= ber_errors_d;
      ber_symbols_q  <= ber_symbols_d;
      lfsr_load_q    <= (state_d == StLoad);
      result_valid_q <= (state_d == StDone);
      busy_q         <= (state_d != StIdle) && (state_d != StFail);
    end
  end

  assign bus_io.lfsr_load    = lfsr_load_q;
  assign bus_io.result_valid = result_valid_q;
  assign bus_io.busy         = busy_q;
  assign bus_io.sync_fail    = sync_fail_q;
  assign bus_io.ber_errors   = ber_errors_q;
  assign bus_io.ber_symbols  = ber_symbols_q;
  assign bus_io.state        = state_q;

endmodule

// File: tb/tb_ber_test_controller.sv
// Self-checking bench for ber_test_controller: phase lengths, sync decisions, windows, abort, reset.
module tb_ber_test_controller;

  localparam int LfsrLen    = 22;
  localparam int SettleSyms = 32;
  localparam int SyncSyms   = 256;
  localparam int WinLen0    = 16384;

  typedef struct packed {
    logic [8:0] n_err;
    logic [8:0] thresh;
    logic       pass;
  } sync_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ber_test_controller_if bus ();

  ber_test_controller dut (
    .sys_clk (clk),
    .reset   (rst_n),
    .bus_io  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of strobes, then sample 1ns after the edge; start/abort are one-cycle pulses.
  task automatic cyc(input logic sam, input logic sym, input logic err);
    bus.sam_clk_en = sam;
    bus.sym_clk_en = sym;
    bus.err_in     = err;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  sync_vec_t vecs[7];

  initial begin
    int load_str, syms, got, extra_load, early_rv, rv_cnt, loads, fail_seen, busy_seen;
    int exp_err, saved_err;
    logic prev_lf, sam, err;

    vecs[0] = '{9'd0,   9'd0,   1'b1};
    vecs[1] = '{9'd1,   9'd0,   1'b0};
    vecs[2] = '{9'd10,  9'd10,  1'b1};
    vecs[3] = '{9'd11,  9'd10,  1'b0};
    vecs[4] = '{9'd256, 9'd255, 1'b0};
    vecs[5] = '{9'd256, 9'd256, 1'b1};
    vecs[6] = '{9'd200, 9'd511, 1'b1};

    bus.sam_clk_en  = 1'b0;
    bus.sym_clk_en  = 1'b0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.continuous  = 1'b0;
    bus.window_sel  = 2'd0;
    bus.sync_thresh = 9'd0;
    bus.err_in      = 1'b0;

    // Reset values
    #2;
    chk("rst_lfsr_load", bus.lfsr_load, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sync_fail", bus.sync_fail, 0);
    chk("rst_ber_errors", bus.ber_errors, 0);
    chk("rst_ber_symbols", bus.ber_symbols, 0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Window 1: zero errors, continuous; window_sel changed after start must not matter
    bus.continuous = 1'b1;
    bus.start = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("start_lfsr_load", bus.lfsr_load, 1);
    chk("start_busy", bus.busy, 1);
    bus.window_sel = 2'd3;
    load_str = 0;
    for (int i = 0; i < 100 && bus.lfsr_load; i++) begin
      load_str++;
      cyc(1'b1, 1'b1, 1'b0);
    end
    chk("load_strobes", load_str, LfsrLen);
    syms = 0; got = 0; extra_load = 0;
    for (int i = 0; i < 20000 && got == 0; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      syms++;
      if (bus.lfsr_load) extra_load++;
      if (bus.result_valid) got = 1;
    end
    chk("w1_result_seen", got, 1);
    chk("w1_symbols_to_result", syms, SettleSyms + SyncSyms + WinLen0);
    chk("w1_ber_errors", bus.ber_errors, 0);
    chk("w1_ber_symbols", bus.ber_symbols, WinLen0);
    chk("w1_busy_in_done", bus.busy, 1);

    // Window 2: back-to-back, random sample gaps and errors; ends in IDLE
    syms = 0; exp_err = 0; early_rv = 0;
    for (int i = 0; i < 60000 && syms < WinLen0; i++) begin
      sam = ($urandom_range(7) != 0);
      err = ($urandom_range(15) == 0);
      cyc(sam, sam, err);
      if (i == 0) bus.continuous = 1'b0;
      if (sam) begin
        syms++;
        if (err) exp_err++;
      end
      if (bus.lfsr_load) extra_load++;
      if (bus.result_valid && syms < WinLen0) early_rv++;
    end
    chk("w2_result_valid", bus.result_valid, 1);
    chk("w2_ber_errors", bus.ber_errors, exp_err);
    chk("w2_ber_symbols", bus.ber_symbols, WinLen0);
    chk("w2_early_result", early_rv, 0);
    chk("no_reload_between_windows", extra_load, 0);
    saved_err = exp_err;
    cyc(1'b0, 1'b0, 1'b0);
    chk("result_valid_one_cycle", bus.result_valid, 0);
    chk("idle_after_done", bus.busy, 0);

    // Sync-window decision boundaries; errors during LOAD/SETTLE must be ignored
    bus.window_sel = 2'd0;
    for (int v = 0; v < 7; v++) begin
      bus.sync_thresh = vecs[v].thresh;
      bus.start = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < LfsrLen + SettleSyms; i++) cyc(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < SyncSyms; i++) cyc(1'b1, 1'b1, (i < int'(vecs[v].n_err)));
      chk($sformatf("sync_vec%0d_reload", v), bus.lfsr_load, !vecs[v].pass);
      chk($sformatf("sync_vec%0d_busy", v), bus.busy, 1);
      bus.abort = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      chk($sformatf("sync_vec%0d_abort_idle", v), bus.busy, 0);
    end
    chk("abort_keeps_ber_errors", bus.ber_errors, saved_err);

    // Persistent errors: three load attempts, then FAIL and IDLE
    bus.sync_thresh = 9'd10;
    bus.start = 1'b1;
    prev_lf = 1'b0; loads = 0; rv_cnt = 0; fail_seen = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc(1'b1, 1'b1, 1'b1);
      if (bus.lfsr_load && !prev_lf) loads++;
      prev_lf = bus.lfsr_load;
      if (bus.result_valid) rv_cnt++;
      if (!bus.busy) begin
        fail_seen = 1;
        break;
      end
    end
    chk("fail_reached", fail_seen, 1);
    chk("fail_load_phases", loads, 3);
    chk("fail_sync_fail", bus.sync_fail, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1);
      if (bus.result_valid) rv_cnt++;
    end
    chk("fail_no_result", rv_cnt, 0);
    chk("fail_sticky", bus.sync_fail, 1);
    chk("fail_then_idle", bus.busy, 0);

    // Abort beats start in IDLE: start is not accepted, sync_fail untouched
    bus.start = 1'b1;
    bus.abort = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("abort_over_start_busy", bus.busy, 0);
    chk("abort_over_start_sync_fail", bus.sync_fail, 1);

    // Abort at MEASURE symbol 5000
    bus.sync_thresh = 9'd511;
    bus.start = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("restart_clears_sync_fail", bus.sync_fail, 0);
    chk("restart_lfsr_load", bus.lfsr_load, 1);
    for (int i = 0; i < LfsrLen + SettleSyms + SyncSyms; i++) cyc(1'b1, 1'b1, 1'b0);
    rv_cnt = 0;
    for (int i = 0; i < 4999; i++) begin
      cyc(1'b1, 1'b1, ($urandom_range(15) == 0));
      if (bus.result_valid) rv_cnt++;
    end
    chk("measure_busy", bus.busy, 1);
    bus.abort = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_lfsr_load", bus.lfsr_load, 0);
    chk("abort_ber_errors", bus.ber_errors, saved_err);
    chk("abort_ber_symbols", bus.ber_symbols, WinLen0);
    for (int i = 0; i < 3; i++) begin
      if (bus.result_valid) rv_cnt++;
      cyc(1'b1, 1'b1, 1'b1);
    end
    chk("abort_no_result", rv_cnt, 0);

    // Reset asserted mid-SYNC acts without a clock edge
    bus.start = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LfsrLen + SettleSyms + 100; i++) cyc(1'b1, 1'b1, 1'b1);
    chk("pre_reset_busy", bus.busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_lfsr_load", bus.lfsr_load, 0);
    chk("async_rst_result_valid", bus.result_valid, 0);
    chk("async_rst_ber_errors", bus.ber_errors, 0);
    chk("async_rst_ber_symbols", bus.ber_symbols, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    busy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (bus.busy || bus.lfsr_load) busy_seen++;
    end
    chk("no_exit_without_start", busy_seen, 0);
    bus.start = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("start_after_reset", bus.lfsr_load, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
